// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and constants for the ibex_mem_responder memory model.
//
// Contents:
//   gnt_state_e            - grant FSM states: IDLE / WAIT / READY
//   resp_t                 - one response beat: rdata, intg check bits, err
//   parameter-range limits - for GntDelay, RespLatency and MaxOutstanding
//   secded_inv_39_32_intg  - check bits of the inverted 39/32 Hsiao code
package ibex_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } gnt_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [6:0]  intg;
    logic        err;
  } resp_t;

  localparam int unsigned GNT_DELAY_MAX    = 15;
  localparam int unsigned GNT_CNT_W        = 4;   // holds 0..GNT_DELAY_MAX
  localparam int unsigned RESP_LAT_MIN     = 1;
  localparam int unsigned RESP_LAT_MAX     = 8;
  localparam int unsigned MAX_OUTSTAND_MIN = 1;

  // Check bits of prim_secded_inv_39_32: Hsiao parity over the data word,
  // then inverted with 7'h2A so that an all-zero codeword is not valid.
  function automatic logic [6:0] secded_inv_39_32_intg(input logic [31:0] data);
    logic [6:0] syn;
    syn[0] = ^(data & 32'h2606_BD25);
    syn[1] = ^(data & 32'hDEBA_8050);
    syn[2] = ^(data & 32'h413D_89AA);
    syn[3] = ^(data & 32'h3123_4ED1);
    syn[4] = ^(data & 32'hC2C1_323B);
    syn[5] = ^(data & 32'h2DCC_624C);
    syn[6] = ^(data & 32'h9850_5586);
    return syn ^ 7'h2A;
  endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response delay line for ibex_mem_responder.
//
// A beat presented on valid_i/resp_i at a rising edge appears on
// valid_o/resp_o for one cycle, Depth-1 edges later (Depth=1 means the cycle
// straight after the edge). Empty stages hold all-zero data so resp_o is 0
// whenever valid_o is 0. rst_i asynchronously empties every stage.
//
// Ports:
//   clk_i, rst_i      - clock, asynchronous active-high clear
//   valid_i, resp_i   - beat to enqueue at this edge
//   valid_o, resp_o   - beat leaving the line
module ibex_mem_resp_pipe
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  valid_i,
  input  resp_t resp_i,
  output logic  valid_o,
  output resp_t resp_o
);

  logic [Depth:0] valid_chain;
  resp_t          resp_chain [Depth+1];

  assign valid_chain[0] = valid_i;
  assign resp_chain[0]  = valid_i ? resp_i : '0;

  for (genvar gi = 0; gi < Depth; gi++) begin : gen_stage
    logic  valid_reg;
    resp_t resp_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_reg <= 1'b0;
        resp_reg  <= '0;
      end else begin
        valid_reg <= valid_chain[gi];
        resp_reg  <= resp_chain[gi];
      end
    end

    assign valid_chain[gi+1] = valid_reg;
    assign resp_chain[gi+1]  = resp_reg;
  end

  assign valid_o = valid_chain[Depth];
  assign resp_o  = resp_chain[Depth];

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the core's req/gnt/rvalid bus.
//
// Accepts word requests (req_i & gnt_o at a rising edge), performs them on a
// byte-enabled word array and returns in-order responses RespLatency cycles
// later. Out-of-range accesses respond with err_o=1 and rdata_o=0.
//
// Optional feature, macro IBEX_MEM_RESP_INTG_EN:
//   defined   - rdata_intg_o carries SECDED check bits of rdata_o, and a write
//               whose wdata_intg_i does not match wdata_i is dropped with err.
//   undefined - rdata_intg_o is 0 and wdata_intg_i is ignored.
//
// Ports:
//   clk_i, rst_i             - clock, asynchronous active-high reset
//   req_i / gnt_o            - request handshake
//   we_i, be_i, addr_i       - write enable, byte enables, byte address
//   wdata_i, wdata_intg_i    - write data and its check bits
//   rvalid_o, rdata_o,
//   rdata_intg_o, err_o      - response beat (all zero when rvalid_o=0)
module ibex_mem_responder
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [GNT_CNT_W-1:0] GntDelayC = GNT_CNT_W'(GntDelay);
  localparam logic [OutW-1:0]      MaxOutC   = OutW'(MaxOutstanding);

  gnt_state_e           gnt_state;
  logic [GNT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [OutW-1:0]      out_cnt_reg, out_cnt_next;
  logic                 accept;

  // ---------------------------------------------------------------------
  // Grant FSM. The state is derived from the registered wait counter so
  // that with GntDelay=0 a fresh request is READY in its first cycle. The
  // counter saturates at GntDelay while the grant is held off by the
  // outstanding limit.
  // ---------------------------------------------------------------------
  always_comb begin
    gnt_state     = IDLE;
    wait_cnt_next = '0;
    if (req_i) begin
      gnt_state = (wait_cnt_reg >= GntDelayC) ? READY : WAIT;
    end
    gnt_o  = req_i && (gnt_state == READY) && (out_cnt_reg < MaxOutC);
    accept = gnt_o;
    if (req_i && !accept) begin
      wait_cnt_next = (gnt_state == READY) ? wait_cnt_reg
                                           : wait_cnt_reg + GNT_CNT_W'(1);
    end
  end

  // Outstanding count: a same-cycle accept and response cancel out.
  always_comb begin
    out_cnt_next = out_cnt_reg;
    if (accept && !rvalid_o) begin
      out_cnt_next = out_cnt_reg + OutW'(1);
    end else if (!accept && rvalid_o) begin
      out_cnt_next = out_cnt_reg - OutW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_reg <= '0;
      out_cnt_reg  <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      out_cnt_reg  <= out_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Address decode and integrity check. BaseAddr is aligned to the array
  // size, so the range test reduces to matching the upper address bits.
  // ---------------------------------------------------------------------
  logic [IdxW-1:0] word_idx;
  logic            in_range;
  logic            intg_ok;
  logic            wr_en;
  logic            unused_inputs;

  assign word_idx = addr_i[IdxW+1:2];
  assign in_range = (addr_i[31:IdxW+2] == BaseAddr[31:IdxW+2]);

`ifdef IBEX_MEM_RESP_INTG_EN
  assign intg_ok       = (wdata_intg_i == secded_inv_39_32_intg(wdata_i));
  assign unused_inputs = ^addr_i[1:0];
`else
  assign intg_ok       = 1'b1;
  assign unused_inputs = ^{addr_i[1:0], wdata_intg_i};
`endif

  assign wr_en = accept && we_i && in_range && intg_ok;

  // Word array, not reset. Only one access happens per edge, so a write at
  // edge N is naturally seen by a read accepted at edge N+1.
  logic [3:0][7:0] mem [MemWords];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem[word_idx][i] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Response for the current request; the first pipe stage registers it at
  // the accept edge, which is also the array read point.
  resp_t resp_in;

  always_comb begin
    resp_in = '0;
    if (!in_range || (we_i && !intg_ok)) begin
      resp_in.err = 1'b1;
    end else if (!we_i) begin
      resp_in.rdata = mem[word_idx];
    end
`ifdef IBEX_MEM_RESP_INTG_EN
    resp_in.intg = secded_inv_39_32_intg(resp_in.rdata);
`endif
  end

  resp_t resp_out;

  ibex_mem_resp_pipe #(
    .Depth (RespLatency)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (accept),
    .resp_i  (resp_in),
    .valid_o (rvalid_o),
    .resp_o  (resp_out)
  );

  assign rdata_o      = resp_out.rdata;
  assign rdata_intg_o = resp_out.intg;
  assign err_o        = resp_out.err;

endmodule
